// File: rtl/udp_roce_qp_table_cm.sv
// RoCEv2 connection manager: assembles 44-byte QP/transfer metadata frames from a UDP
// payload stream of any width into a QP table and issues per-transfer TX descriptors.
module udp_roce_qp_table_cm #(
    parameter int          DATA_WIDTH      = 64,
    parameter int          KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int          NUM_QP          = 4,
    parameter int          QP_IDX_W        = (NUM_QP > 1) ? $clog2(NUM_QP) : 1,
    parameter logic [15:0] LISTEN_UDP_PORT = 16'h4321
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s_udp_hdr_valid,
    output logic                  s_udp_hdr_ready,
    input  logic [15:0]           s_udp_dest_port,
    input  logic [15:0]           s_udp_length,
    input  logic [DATA_WIDTH-1:0] s_udp_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_udp_payload_axis_tkeep,
    input  logic                  s_udp_payload_axis_tvalid,
    output logic                  s_udp_payload_axis_tready,
    input  logic                  s_udp_payload_axis_tlast,
    input  logic                  s_udp_payload_axis_tuser,

    output logic                  m_txmeta_valid,
    input  logic                  m_txmeta_ready,
    output logic [QP_IDX_W-1:0]   m_txmeta_qp_idx,
    output logic [23:0]           m_txmeta_rem_qpn,
    output logic [23:0]           m_txmeta_loc_qpn,
    output logic [23:0]           m_txmeta_rem_psn,
    output logic [23:0]           m_txmeta_loc_psn,
    output logic [31:0]           m_txmeta_r_key,
    output logic [63:0]           m_txmeta_rem_addr,
    output logic [31:0]           m_txmeta_rem_ip_addr,
    output logic [31:0]           m_txmeta_dma_length,
    output logic [15:0]           m_txmeta_rem_udp_port,
    output logic                  m_txmeta_is_immediate,
    output logic                  m_txmeta_tx_type,

    output logic [NUM_QP-1:0]     qp_entry_valid,
    output logic [15:0]           frame_count,
    output logic [15:0]           err_count,
    output logic                  busy
);

    localparam int          FRAME_BYTES   = 44;
    localparam int          TOP           = FRAME_BYTES * 8 - 1;
    localparam logic [15:0] FRAME_UDP_LEN = 16'd52;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, COMMIT, EMIT} state_t;

    state_t state, state_next;

    // Frame byte k lives at frame_buf[TOP-8k -: 8], so big-endian fields are plain slices.
    logic [TOP:0]          frame_buf;
    logic [5:0]            byte_cnt;
    logic [7:0]            beat_bytes;
    logic [7:0]            cnt_sum;
    logic [5:0]            cnt_next;
    logic                  hdr_fire;
    logic                  beat_fire;
    logic                  frame_ok;
    logic                  emit_go;

    logic [23:0] tbl_rem_qpn [NUM_QP];
    logic [23:0] tbl_loc_qpn [NUM_QP];
    logic [23:0] tbl_rem_psn [NUM_QP];
    logic [23:0] tbl_loc_psn [NUM_QP];
    logic [31:0] tbl_r_key   [NUM_QP];
    logic [63:0] tbl_base    [NUM_QP];

    logic                  f_qp_valid, f_qp_close, f_tx_valid, f_start, f_imm, f_type;
    logic [23:0]           f_rem_qpn, f_loc_qpn, f_rem_psn, f_loc_psn;
    logic [31:0]           f_r_key, f_rem_ip, f_dma_len;
    logic [63:0]           f_base, f_addr_off;
    logic [15:0]           f_udp_port;
    logic [QP_IDX_W-1:0]   slot;
    logic                  unused_ctl_bits;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) c = c + 8'(k[i]);
        return c;
    endfunction

    assign f_qp_valid      = frame_buf[TOP - 7];
    assign f_qp_close      = frame_buf[TOP - 6];
    assign f_rem_qpn       = frame_buf[TOP - 8*1  -: 24];
    assign f_loc_qpn       = frame_buf[TOP - 8*4  -: 24];
    assign f_rem_psn       = frame_buf[TOP - 8*7  -: 24];
    assign f_loc_psn       = frame_buf[TOP - 8*10 -: 24];
    assign f_r_key         = frame_buf[TOP - 8*13 -: 32];
    assign f_base          = frame_buf[TOP - 8*17 -: 64];
    assign f_tx_valid      = frame_buf[TOP - 8*25 - 7];
    assign f_start         = frame_buf[TOP - 8*25 - 6];
    assign f_imm           = frame_buf[TOP - 8*25 - 5];
    assign f_type          = frame_buf[TOP - 8*25 - 4];
    assign f_rem_ip        = frame_buf[TOP - 8*26 -: 32];
    assign f_addr_off      = frame_buf[TOP - 8*30 -: 64];
    assign f_dma_len       = frame_buf[TOP - 8*38 -: 32];
    assign f_udp_port      = frame_buf[TOP - 8*42 -: 16];
    assign unused_ctl_bits = ^{frame_buf[TOP -: 6], frame_buf[TOP - 8*25 -: 4]};

    assign slot       = f_loc_qpn[QP_IDX_W-1:0] & QP_IDX_W'(NUM_QP - 1);
    assign hdr_fire   = s_udp_hdr_valid && s_udp_hdr_ready;
    assign beat_fire  = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
    assign beat_bytes = popcount(s_udp_payload_axis_tkeep);
    assign cnt_sum    = 8'(byte_cnt) + beat_bytes;
    assign cnt_next   = (cnt_sum >= 8'(FRAME_BYTES)) ? 6'(FRAME_BYTES) : cnt_sum[5:0];
    assign frame_ok   = (cnt_next == 6'(FRAME_BYTES)) && !s_udp_payload_axis_tuser;
    assign emit_go    = (state == EMIT) && (!m_txmeta_valid || m_txmeta_ready);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (hdr_fire)
                         state_next = (s_udp_dest_port == LISTEN_UDP_PORT &&
                                       s_udp_length == FRAME_UDP_LEN) ? READ : DRAIN;
            READ:    if (beat_fire && s_udp_payload_axis_tlast)
                         state_next = frame_ok ? COMMIT : IDLE;
            DRAIN:   if (beat_fire && s_udp_payload_axis_tlast) state_next = IDLE;
            COMMIT:  state_next = (f_tx_valid && f_start) ? EMIT : IDLE;
            EMIT:    if (emit_go) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_udp_hdr_ready           = !rst && (state == IDLE) && !m_txmeta_valid;
        s_udp_payload_axis_tready = !rst && (state == READ || state == DRAIN);
        busy                      = !rst && (state != IDLE);
    end

    // Payload assembly: lanes land at the running byte offset; bytes past the frame drop.
    always_ff @(posedge clk) begin
        if (state == READ && beat_fire) begin
            for (int i = 0; i < KEEP_WIDTH; i++) begin
                if (s_udp_payload_axis_tkeep[i] && (int'(byte_cnt) + i) < FRAME_BYTES)
                    frame_buf[9'(TOP - 8 * (int'(byte_cnt) + i)) -: 8] <= s_udp_payload_axis_tdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == COMMIT && f_qp_valid) begin
            tbl_rem_qpn[slot] <= f_rem_qpn;
            tbl_loc_qpn[slot] <= f_loc_qpn;
            tbl_rem_psn[slot] <= f_rem_psn;
            tbl_loc_psn[slot] <= f_loc_psn;
            tbl_r_key[slot]   <= f_r_key;
            tbl_base[slot]    <= f_base;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt              <= '0;
            qp_entry_valid        <= '0;
            frame_count           <= '0;
            err_count             <= '0;
            m_txmeta_valid        <= 1'b0;
            m_txmeta_qp_idx       <= '0;
            m_txmeta_rem_qpn      <= '0;
            m_txmeta_loc_qpn      <= '0;
            m_txmeta_rem_psn      <= '0;
            m_txmeta_loc_psn      <= '0;
            m_txmeta_r_key        <= '0;
            m_txmeta_rem_addr     <= '0;
            m_txmeta_rem_ip_addr  <= '0;
            m_txmeta_dma_length   <= '0;
            m_txmeta_rem_udp_port <= '0;
            m_txmeta_is_immediate <= 1'b0;
            m_txmeta_tx_type      <= 1'b0;
        end else begin
            if (hdr_fire) byte_cnt <= '0;
            if (state == READ && beat_fire) begin
                byte_cnt <= cnt_next;
                if (s_udp_payload_axis_tlast && !frame_ok) err_count <= sat_inc(err_count);
            end

            if (state == COMMIT) begin
                frame_count <= sat_inc(frame_count);
                if (f_qp_valid)      qp_entry_valid[slot] <= 1'b1;
                else if (f_qp_close) qp_entry_valid[slot] <= 1'b0;
            end

            if (m_txmeta_valid && m_txmeta_ready) m_txmeta_valid <= 1'b0;

            // Table was written at COMMIT, so a slot opened by this same frame is visible here.
            if (emit_go) begin
                if (qp_entry_valid[slot]) begin
                    m_txmeta_valid        <= 1'b1;
                    m_txmeta_qp_idx       <= slot;
                    m_txmeta_rem_qpn      <= tbl_rem_qpn[slot];
                    m_txmeta_loc_qpn      <= tbl_loc_qpn[slot];
                    m_txmeta_rem_psn      <= tbl_rem_psn[slot];
                    m_txmeta_loc_psn      <= tbl_loc_psn[slot];
                    m_txmeta_r_key        <= tbl_r_key[slot];
                    m_txmeta_rem_addr     <= tbl_base[slot] + f_addr_off;
                    m_txmeta_rem_ip_addr  <= f_rem_ip;
                    m_txmeta_dma_length   <= f_dma_len;
                    m_txmeta_rem_udp_port <= f_udp_port;
                    m_txmeta_is_immediate <= f_imm;
                    m_txmeta_tx_type      <= f_type;
                end else begin
                    err_count <= sat_inc(err_count);
                end
            end
        end
    end

endmodule
